// File: rtl/argmax_pkg.sv
// Shared definitions for the streaming argmax unit: FSM encoding and an
// elaboration-time ceiling-log2 helper used for width checks.
package argmax_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v * 2;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/argmax_compare.sv
// Combinational replace decision: the first element always wins, later
// elements win only when strictly greater, so ties keep the earlier index.
module argmax_compare #(
    parameter int DATA_WIDTH  = 32,
    parameter int SIGNED_MODE = 0
) (
    input  logic [DATA_WIDTH-1:0] i_candidate,
    input  logic [DATA_WIDTH-1:0] i_best,
    input  logic                  i_first,
    output logic                  o_take_candidate
);

    logic w_gt_signed;
    logic w_gt_unsigned;

    assign w_gt_signed   = ($signed(i_candidate) > $signed(i_best));
    assign w_gt_unsigned = (i_candidate > i_best);

    // Select the compare semantics and apply the first-element override.
    always_comb begin
        o_take_candidate = 1'b0;
        if (i_first) begin
            o_take_candidate = 1'b1;
        end else if (SIGNED_MODE != 0) begin
            o_take_candidate = w_gt_signed;
        end else begin
            o_take_candidate = w_gt_unsigned;
        end
    end

endmodule

// File: rtl/argmax_stream_unit.sv
// Streaming argmax: indexes VECTOR_LENGTH accepted scores and presents the
// winning index and value through a valid/ready result handshake.
module argmax_stream_unit
    import argmax_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int VECTOR_LENGTH = 10,
    parameter int INDEX_WIDTH   = 8,
    parameter int SIGNED_MODE   = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic [DATA_WIDTH-1:0]  in_value,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [INDEX_WIDTH-1:0] out_index,
    output logic [DATA_WIDTH-1:0]  out_value,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam int CNT_W = (clog2(VECTOR_LENGTH) < 1) ? 1 : clog2(VECTOR_LENGTH);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(VECTOR_LENGTH - 1);

    if (VECTOR_LENGTH < 1) begin : g_len_check
        $error("argmax_stream_unit: VECTOR_LENGTH must be at least 1");
    end
    if (INDEX_WIDTH < clog2(VECTOR_LENGTH)) begin : g_index_check
        $error("argmax_stream_unit: INDEX_WIDTH too narrow for VECTOR_LENGTH");
    end

    state_t                 r_state;
    logic [CNT_W-1:0]       r_count;
    logic [DATA_WIDTH-1:0]  r_best_value;
    logic [INDEX_WIDTH-1:0] r_best_index;
    logic                   r_out_valid;
    logic [INDEX_WIDTH-1:0] r_out_index;
    logic [DATA_WIDTH-1:0]  r_out_value;

    state_t                 w_state_next;
    logic [CNT_W-1:0]       w_count_next;
    logic [DATA_WIDTH-1:0]  w_best_value_next;
    logic [INDEX_WIDTH-1:0] w_best_index_next;
    logic                   w_out_valid_next;
    logic [INDEX_WIDTH-1:0] w_out_index_next;
    logic [DATA_WIDTH-1:0]  w_out_value_next;

    logic                   w_first;
    logic                   w_last;
    logic                   w_take;
    logic [DATA_WIDTH-1:0]  w_merge_value;
    logic [INDEX_WIDTH-1:0] w_merge_index;

    assign w_first = (r_count == {CNT_W{1'b0}});
    assign w_last  = (r_count == LAST_COUNT);

    argmax_compare #(
        .DATA_WIDTH  (DATA_WIDTH),
        .SIGNED_MODE (SIGNED_MODE)
    ) u_compare (
        .i_candidate      (in_value),
        .i_best           (r_best_value),
        .i_first          (w_first),
        .o_take_candidate (w_take)
    );

    // Best-so-far including the element on the input this cycle.
    assign w_merge_value = w_take ? in_value : r_best_value;
    assign w_merge_index = w_take ? INDEX_WIDTH'(r_count) : r_best_index;

    assign in_ready  = (r_state == ACCUM);
    assign out_valid = r_out_valid;
    assign out_index = r_out_index;
    assign out_value = r_out_value;

    // Next-state and datapath update; clear overrides any accept or handshake.
    always_comb begin
        w_state_next      = r_state;
        w_count_next      = r_count;
        w_best_value_next = r_best_value;
        w_best_index_next = r_best_index;
        w_out_valid_next  = r_out_valid;
        w_out_index_next  = r_out_index;
        w_out_value_next  = r_out_value;
        if (clear) begin
            w_state_next      = ACCUM;
            w_count_next      = {CNT_W{1'b0}};
            w_best_value_next = {DATA_WIDTH{1'b0}};
            w_best_index_next = {INDEX_WIDTH{1'b0}};
            w_out_valid_next  = 1'b0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (in_valid) begin
                        w_best_value_next = w_merge_value;
                        w_best_index_next = w_merge_index;
                        if (w_last) begin
                            w_count_next     = {CNT_W{1'b0}};
                            w_out_valid_next = 1'b1;
                            w_out_index_next = w_merge_index;
                            w_out_value_next = w_merge_value;
                            w_state_next     = HOLD;
                        end else begin
                            w_count_next = r_count + CNT_W'(1);
                        end
                    end else begin
                        w_state_next = ACCUM;
                    end
                end
                HOLD: begin
                    if (r_out_valid && out_ready) begin
                        w_out_valid_next = 1'b0;
                        w_state_next     = ACCUM;
                    end else begin
                        w_state_next = HOLD;
                    end
                end
                default: begin
                    w_state_next     = ACCUM;
                    w_count_next     = {CNT_W{1'b0}};
                    w_out_valid_next = 1'b0;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Counter, running best and registered result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count      <= {CNT_W{1'b0}};
            r_best_value <= {DATA_WIDTH{1'b0}};
            r_best_index <= {INDEX_WIDTH{1'b0}};
            r_out_valid  <= 1'b0;
            r_out_index  <= {INDEX_WIDTH{1'b0}};
            r_out_value  <= {DATA_WIDTH{1'b0}};
        end else begin
            r_count      <= w_count_next;
            r_best_value <= w_best_value_next;
            r_best_index <= w_best_index_next;
            r_out_valid  <= w_out_valid_next;
            r_out_index  <= w_out_index_next;
            r_out_value  <= w_out_value_next;
        end
    end

endmodule

// File: tb/tb_argmax_stream_unit.sv
// Directed, table-driven bench: an unsigned and a signed instance share the
// same stimulus, each checked against hand-computed expectations.
module tb_argmax_stream_unit;

    logic        clk;
    logic        rst;
    logic        clear;
    logic [31:0] in_value;
    logic        in_valid;
    logic        out_ready;

    logic        ir_u, ov_u, ir_s, ov_s;
    logic [1:0]  oi_u, oi_s;
    logic [31:0] oval_u, oval_s;

    int checks;
    int errors;

    typedef struct {
        logic        v;
        logic [31:0] val;
        logic        clr;
        logic        ord;
        logic        exp_ir;
        logic        exp_ov;
        logic [1:0]  ui;
        logic [31:0] uv;
        logic [1:0]  si;
        logic [31:0] sv;
    } row_t;

    row_t rows[$];

    argmax_stream_unit #(
        .DATA_WIDTH(32), .VECTOR_LENGTH(4), .INDEX_WIDTH(2), .SIGNED_MODE(0)
    ) u_dut_u (
        .clk(clk), .rst(rst), .clear(clear), .in_value(in_value),
        .in_valid(in_valid), .in_ready(ir_u), .out_index(oi_u),
        .out_value(oval_u), .out_valid(ov_u), .out_ready(out_ready)
    );

    argmax_stream_unit #(
        .DATA_WIDTH(32), .VECTOR_LENGTH(4), .INDEX_WIDTH(2), .SIGNED_MODE(1)
    ) u_dut_s (
        .clk(clk), .rst(rst), .clear(clear), .in_value(in_value),
        .in_valid(in_valid), .in_ready(ir_s), .out_index(oi_s),
        .out_value(oval_s), .out_valid(ov_s), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic [31:0] val, input logic clr,
                       input logic ord, input logic ir, input logic ov,
                       input logic [1:0] ui, input logic [31:0] uv,
                       input logic [1:0] si, input logic [31:0] sv);
        row_t r;
        r = '{v, val, clr, ord, ir, ov, ui, uv, si, sv};
        rows.push_back(r);
    endtask

    task automatic add_same(input logic v, input logic [31:0] val, input logic clr,
                            input logic ord, input logic ir, input logic ov,
                            input logic [1:0] idx, input logic [31:0] value);
        add(v, val, clr, ord, ir, ov, idx, value, idx, value);
    endtask

    task automatic check_row(input row_t r, input int n);
        chk($sformatf("row%0d in_ready_u", n), {31'd0, ir_u}, {31'd0, r.exp_ir});
        chk($sformatf("row%0d in_ready_s", n), {31'd0, ir_s}, {31'd0, r.exp_ir});
        chk($sformatf("row%0d out_valid_u", n), {31'd0, ov_u}, {31'd0, r.exp_ov});
        chk($sformatf("row%0d out_valid_s", n), {31'd0, ov_s}, {31'd0, r.exp_ov});
        if (r.exp_ov) begin
            chk($sformatf("row%0d out_index_u", n), {30'd0, oi_u}, {30'd0, r.ui});
            chk($sformatf("row%0d out_value_u", n), oval_u, r.uv);
            chk($sformatf("row%0d out_index_s", n), {30'd0, oi_s}, {30'd0, r.si});
            chk($sformatf("row%0d out_value_s", n), oval_s, r.sv);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_value  = 32'd0;
        out_ready = 1'b1;

        // Unsigned basic: 5,9,2,7 -> idx1 val9, one-cycle in_ready bubble.
        add_same(1'b1, 32'd5, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 32'd0);
        add_same(1'b1, 32'd9, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 32'd0);
        add_same(1'b1, 32'd2, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 32'd0);
        add_same(1'b1, 32'd7, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 32'd9);
        add_same(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 32'd0);
        // Backpressure: result held 5 cycles, vector of 1s refused meanwhile.
        add_same(1'b1, 32'd5, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 32'd0);
        add_same(1'b1, 32'd9, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 32'd0);
        add_same(1'b1, 32'd2, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 32'd0);
        add_same(1'b1, 32'd7, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 32'd9);
        for (int i = 0; i < 5; i++)
            add_same(1'b1, 32'd1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 32'd9);
        add_same(1'b1, 32'd1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 32'd0);
        for (int i = 0; i < 3; i++)
            add_same(1'b1, 32'd1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 32'd0);
        add_same(1'b1, 32'd1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 32'd1);
        add_same(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 32'd0);
        // Gaps: 4, -, -, -, 8, 8, -, 6 -> idx1 val8.
        add_same(1'b1, 32'd4, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 32'd0);
        for (int i = 0; i < 3; i++)
            add_same(1'b0, 32'd99, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 32'd0);
        add_same(1'b1, 32'd8, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 32'd0);
        add_same(1'b1, 32'd8, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 32'd0);
        add_same(1'b0, 32'd99, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 32'd0);
        add_same(1'b1, 32'd6, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 32'd8);
        add_same(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 32'd0);
        // Clear mid-vector drops 300; clear in HOLD drops the result.
        add_same(1'b1, 32'd100, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 32'd0);
        add_same(1'b1, 32'd200, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 32'd0);
        add_same(1'b1, 32'd300, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 32'd0);
        add_same(1'b1, 32'd1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 32'd0);
        add_same(1'b1, 32'd2, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 32'd0);
        add_same(1'b1, 32'd3, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 32'd0);
        add_same(1'b1, 32'd4, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 32'd4);
        add_same(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 32'd0);
        // Tie and sign: -1, 3, min, 3.
        add(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 32'd0, 2'd0, 32'd0);
        add(1'b1, 32'd3, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 32'd0, 2'd0, 32'd0);
        add(1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 32'd0, 2'd0, 32'd0);
        add(1'b1, 32'd3, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 32'hFFFF_FFFF, 2'd1, 32'd3);
        add(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 32'd0, 2'd0, 32'd0);
        // Extremes: min, max, 0, all-ones.
        add(1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 32'd0, 2'd0, 32'd0);
        add(1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 32'd0, 2'd0, 32'd0);
        add(1'b1, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 32'd0, 2'd0, 32'd0);
        add(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 32'hFFFF_FFFF, 2'd1, 32'h7FFF_FFFF);
        add(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 32'd0, 2'd0, 32'd0);

        // Reset state.
        #2;
        chk("reset in_ready", {30'd0, ir_u, ir_s}, 32'd3);
        chk("reset out_valid", {30'd0, ov_u, ov_s}, 32'd0);
        chk("reset out_index", {28'd0, oi_u, oi_s}, 32'd0);
        chk("reset out_value", oval_u | oval_s, 32'd0);
        @(posedge clk);
        #3;
        rst = 1'b0;

        foreach (rows[n]) begin
            in_valid  = rows[n].v;
            in_value  = rows[n].val;
            clear     = rows[n].clr;
            out_ready = rows[n].ord;
            tick();
            check_row(rows[n], n);
        end
        clear = 1'b0;

        // Async reset after 2 of 4 elements; beat during reset is not captured.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_value  = 32'd50;
        tick();
        in_value = 32'd60;
        tick();
        in_value = 32'd99;
        #2;
        rst = 1'b1;
        #1;
        chk("async rst out_valid", {30'd0, ov_u, ov_s}, 32'd0);
        chk("async rst in_ready", {30'd0, ir_u, ir_s}, 32'd3);
        tick();
        #2;
        rst = 1'b0;
        in_value = 32'd7;
        tick();
        in_value = 32'd6;
        tick();
        in_value = 32'd5;
        tick();
        chk("post rst not done", {30'd0, ov_u, ov_s}, 32'd0);
        in_value = 32'd4;
        tick();
        chk("post rst out_valid", {30'd0, ov_u, ov_s}, 32'd3);
        chk("post rst out_index_u", {30'd0, oi_u}, 32'd0);
        chk("post rst out_value_u", oval_u, 32'd7);
        chk("post rst out_index_s", {30'd0, oi_s}, 32'd0);
        chk("post rst out_value_s", oval_s, 32'd7);

        // Reset while a result is pending clears out_valid without an edge.
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        chk("hold before rst", {30'd0, ov_u, ov_s}, 32'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("hold rst out_valid", {30'd0, ov_u, ov_s}, 32'd0);
        chk("hold rst out_value", oval_u | oval_s, 32'd0);
        #2;
        rst = 1'b0;
        tick();
        chk("after hold rst in_ready", {30'd0, ir_u, ir_s}, 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
